ddr2_traffic_gen: RTL and testbench
===================================

Name: ddr2_traffic_gen

Overview:
Parametrised, self-checking traffic generator that drives the DDR2 controller host port in place of the file-based controller driver. After a start pulse and controller READY, it performs a write pass and then a read pass over a configurable address window, in scalar or block mode. It checks every returned word against an address-derived pattern and reports pass/fail, error and read counts, and timeout. It is instantiated beside ddr2_controller and feeds the same CMD/SZ/OP/DIN/ADDR/FETCHING nets.

Parameters:
ADDR_W, 25, host address width
DATA_W, 16, host data width
NUM_XFERS, 64, transactions per pass (1..65535)
BASE_ADDR, 0, first address of the window
SEED, 16'hA5C3, pattern XOR seed (DATA_W bits)
FILL_LIMIT, 56, issue stalls while fillcount > FILL_LIMIT
DRAIN_TIMEOUT, 4096, max cycles in DRAIN without a validout

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run (ignored while busy=1)
mode  in  1  0 = scalar (SCW/SCR), 1 = block (BLW/BLR); sampled at start
blk_sz  in  2  block size code, sampled at start; BL = 8*(blk_sz+1) words
ready  in  1  controller initialised
notfull  in  1  controller accepts a beat this cycle
fillcount  in  7  controller input-queue occupancy
dout  in  DATA_W  returned read data
raddr  in  ADDR_W  address of returned word
validout  in  1  dout/raddr valid
cmd  out  3  000 NOP, 001 SCR, 010 SCW, 011 BLR, 100 BLW
sz  out  2  block size code (= latched blk_sz; 00 in scalar mode)
op  out  3  always 000
fetching  out  1  readback accept; high in READ and DRAIN
din  out  DATA_W  write data
addr  out  ADDR_W  transaction address
busy  out  1  run in progress
done  out  1  run finished; held until next start
pass  out  1  valid with done: err_count==0, all reads returned, no timeout
err_count  out  16  mismatches, saturating at 16'hFFFF
rd_count  out  16  returned words counted, saturating at 16'hFFFF
timeout  out  1  DRAIN watchdog expired

Behaviour:
- Reset (async): all outputs 0, cmd=NOP, state IDLE; counters and latched mode/blk_sz cleared. Reset mid-run aborts immediately; no partial status is kept.
- Pattern: pat(a) = a[DATA_W-1:0] ^ SEED ^ zero-extended a[ADDR_W-1:DATA_W].
- Words per transaction: W = 1 (scalar) or BL (block). Stride = W. Transaction i has base address A_i = BASE_ADDR + i*W, computed modulo 2^ADDR_W (wraps).
- Expected read total: E = NUM_XFERS*W, held in a 32-bit register.
- States:
  - IDLE: on start, latch mode/blk_sz, clear counters, done, pass, timeout; set busy=1; go to WAIT_RDY.
  - WAIT_RDY: cmd=NOP; go to WRITE when ready=1. If ready=1 already, the transition happens on the next cycle.
  - WRITE: present a beat (cmd=SCW/BLW, sz, addr=A_i, din=pat(A_i+k)) for word k.
    - A beat is accepted on a clk edge where notfull=1 and fillcount <= FILL_LIMIT; otherwise all outputs hold.
    - Block mode: BL consecutive accepted beats share addr=A_i, with k = 0..BL-1.
    - After the last beat of transaction NUM_XFERS-1, go to READ with i=0 and cmd=NOP for one cycle.
  - READ: one accepted beat per transaction, with cmd=SCR/BLR and addr=A_i; fetching=1. After the last accepted beat, go to DRAIN.
  - DRAIN: cmd=NOP, fetching=1. Go to DONE when rd_count reaches E, or when the watchdog reaches DRAIN_TIMEOUT (set timeout=1). The watchdog resets on every validout.
  - DONE: busy=0, done=1, fetching=0; pass registered. Go to IDLE on the next cycle; done/pass are held until the next start.
- Checking: active in READ and DRAIN.
  - Each cycle with validout=1: rd_count++.
  - err_count++ if dout != pat(raddr), or if raddr lies outside [BASE_ADDR, BASE_ADDR+E) (modulo window).
  - validout while not in READ/DRAIN is ignored.
  - Extra words beyond E are counted and flagged as errors if they arrive before DONE.
- Simultaneous events: validout in the same cycle the last read beat is accepted is counted normally. start while busy is ignored. ready dropping mid-run does not pause the generator; only notfull/fillcount throttle.
- pass = (err_count==0) && (rd_count==E) && !timeout.

Test Plan:
- Scalar run: NUM_XFERS=4, BASE_ADDR=0x10, ideal controller (notfull=1, fillcount=0). Expect 4 SCW beats to 0x10..0x13 with din=0x10^0xA5C3=0xA5D3 for the first beat, then 4 SCR beats; return 4 correct words -> done=1, pass=1, rd_count=4.
- Block run: mode=1, blk_sz=01 (BL=16), NUM_XFERS=2. Expect 32 BLW beats (addr 0x0 ×16, then 0x10 ×16) followed by 2 BLR beats; return 32 words -> rd_count=32, pass=1.
- Throttle: hold notfull=0 for 10 cycles mid-WRITE, then force fillcount=57. cmd/addr/din must stay frozen throughout and resume on the first cycle with notfull=1 and fillcount<=56; no beat is duplicated or skipped.
- Corruption: flip dout bit 0 on 2 of 4 returned words -> err_count=2, pass=0. Also return raddr=BASE_ADDR+E -> err_count increments.
- Timeout: DRAIN_TIMEOUT=100, withhold one read word -> timeout=1 at 100 cycles, done=1, pass=0, rd_count=E-1.
- Reset/restart: assert reset during WRITE -> outputs 0 immediately (cmd=NOP, busy=0). A subsequent start runs cleanly to pass=1. start while busy has no effect.

Source files
------------

// File: rtl/ddr2_traffic_gen.sv
// Self-checking DDR2 host-port traffic generator: a write pass, then a read pass
// over an address window, checking every returned word against an address pattern.
module ddr2_traffic_gen #(
  parameter int                ADDR_W        = 25,
  parameter int                DATA_W        = 16,
  parameter int                NUM_XFERS     = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [DATA_W-1:0] SEED          = 16'hA5C3,
  parameter int                FILL_LIMIT    = 56,
  parameter int                DRAIN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [1:0]        blk_sz,
  input  logic              ready,
  input  logic              notfull,
  input  logic [6:0]        fillcount,
  input  logic [DATA_W-1:0] dout,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              validout,
  output logic [2:0]        cmd,
  output logic [1:0]        sz,
  output logic [2:0]        op,
  output logic              fetching,
  output logic [DATA_W-1:0] din,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [15:0]       rd_count,
  output logic              timeout
);

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_SCR = 3'b001;
  localparam logic [2:0] CMD_SCW = 3'b010;
  localparam logic [2:0] CMD_BLR = 3'b011;
  localparam logic [2:0] CMD_BLW = 3'b100;
  localparam logic [15:0] LAST_XFER = 16'(NUM_XFERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_WRITE, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t      state;
  logic        mode_r;
  logic [5:0]  stride;
  logic [5:0]  word_k;
  logic [15:0] xfer_idx;
  logic [31:0] exp_total;
  logic [31:0] rd_total;
  logic [31:0] wd;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    pat = DATA_W'(a) ^ SEED ^ DATA_W'(a >> DATA_W);
  endfunction

  logic              accept;
  logic              rx;
  logic              word_bad;
  logic [ADDR_W-1:0] rd_off;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] next_word_addr;
  logic [5:0]        words_in;

  assign op             = CMD_NOP;
  assign accept         = notfull && ({25'd0, fillcount} <= 32'(FILL_LIMIT));
  assign rx             = validout && (state == S_READ || state == S_DRAIN);
  assign rd_off         = raddr - BASE_ADDR;
  // Out-of-window addresses and surplus words both count as mismatches.
  assign word_bad       = (dout != pat(raddr)) || !(64'(rd_off) < 64'(exp_total)) ||
                          (rd_total >= exp_total);
  assign next_addr      = addr + ADDR_W'(stride);
  assign next_word_addr = addr + ADDR_W'(word_k) + ADDR_W'(1);
  assign words_in       = mode ? ({1'b0, blk_sz, 3'b000} + 6'd8) : 6'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mode_r    <= 1'b0;
      stride    <= '0;
      word_k    <= '0;
      xfer_idx  <= '0;
      exp_total <= '0;
      rd_total  <= '0;
      wd        <= '0;
      cmd       <= CMD_NOP;
      sz        <= '0;
      fetching  <= 1'b0;
      din       <= '0;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      rd_count  <= '0;
      timeout   <= 1'b0;
    end else begin
      if (rx) begin
        rd_total <= rd_total + 32'd1;
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
        if (word_bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r    <= mode;
            sz        <= mode ? blk_sz : 2'b00;
            stride    <= words_in;
            exp_total <= 32'(NUM_XFERS) * {26'd0, words_in};
            rd_total  <= '0;
            rd_count  <= '0;
            err_count <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b1;
            xfer_idx  <= '0;
            word_k    <= '0;
            wd        <= '0;
            state     <= S_WAIT_RDY;
          end
        end
        S_WAIT_RDY: begin
          if (ready) begin
            cmd   <= mode_r ? CMD_BLW : CMD_SCW;
            addr  <= BASE_ADDR;
            din   <= pat(BASE_ADDR);
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (accept) begin
            if (word_k != stride - 6'd1) begin
              word_k <= word_k + 6'd1;
              din    <= pat(next_word_addr);
            end else begin
              word_k <= '0;
              if (xfer_idx == LAST_XFER) begin
                xfer_idx <= '0;
                cmd      <= CMD_NOP;
                addr     <= BASE_ADDR;
                fetching <= 1'b1;
                state    <= S_READ;
              end else begin
                xfer_idx <= xfer_idx + 16'd1;
                addr     <= next_addr;
                din      <= pat(next_addr);
              end
            end
          end
        end
        S_READ: begin
          // The first READ cycle is a NOP gap between the two passes.
          if (cmd == CMD_NOP) begin
            cmd <= mode_r ? CMD_BLR : CMD_SCR;
          end else if (accept) begin
            if (xfer_idx == LAST_XFER) begin
              cmd   <= CMD_NOP;
              wd    <= '0;
              state <= S_DRAIN;
            end else begin
              xfer_idx <= xfer_idx + 16'd1;
              addr     <= next_addr;
            end
          end
        end
        S_DRAIN: begin
          if (rd_total >= exp_total) begin
            fetching <= 1'b0;
            state    <= S_DONE;
          end else if (validout) begin
            wd <= '0;
          end else if (wd >= 32'(DRAIN_TIMEOUT - 1)) begin
            timeout  <= 1'b1;
            fetching <= 1'b0;
            state    <= S_DONE;
          end else begin
            wd <= wd + 32'd1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (err_count == 16'd0) && (rd_total == exp_total) && !timeout;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench for ddr2_traffic_gen: an ideal controller model that checks every
// accepted beat and returns read data, with table-driven runs plus corner sequences.
module tb_ddr2_traffic_gen;

  localparam logic [24:0] BASE = 25'h10;
  localparam int          NX   = 4;

  logic        clk = 1'b0;
  logic        reset, start, mode, ready, notfull, validout;
  logic [1:0]  blk_sz;
  logic [6:0]  fillcount;
  logic [15:0] dout;
  logic [24:0] raddr;
  logic [2:0]  cmd, op;
  logic [1:0]  sz;
  logic        fetching, busy, done, pass, timeout;
  logic [15:0] din, err_count, rd_count;
  logic [24:0] addr;

  ddr2_traffic_gen #(
    .ADDR_W(25), .DATA_W(16), .NUM_XFERS(NX), .BASE_ADDR(BASE),
    .SEED(16'hA5C3), .FILL_LIMIT(56), .DRAIN_TIMEOUT(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .blk_sz(blk_sz),
    .ready(ready), .notfull(notfull), .fillcount(fillcount), .dout(dout),
    .raddr(raddr), .validout(validout), .cmd(cmd), .sz(sz), .op(op),
    .fetching(fetching), .din(din), .addr(addr), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .rd_count(rd_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scenario knobs read by the controller model
  logic        cfg_mode = 1'b0;
  logic [1:0]  cfg_bsz  = 2'd0;
  logic [31:0] cfg_mask = 32'd0;
  int          cfg_drop = -1;
  int          cfg_oow  = -1;

  function automatic logic [15:0] pat(input logic [24:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {7'd0, a[24:16]};
  endfunction

  function automatic int words_cur();
    return cfg_mode ? 8 * (int'(cfg_bsz) + 1) : 1;
  endfunction

  function automatic logic [24:0] exp_wr_addr(input int beat);
    int w;
    w = words_cur();
    return BASE + 25'((beat / w) * w);
  endfunction

  function automatic logic [15:0] exp_wr_din(input int beat);
    return pat(exp_wr_addr(beat) + 25'(beat % words_cur()));
  endfunction

  int          wr_beat, rd_beat, ret_idx;
  logic [24:0] rq[$];

  // Controller model: checks accepted beats at negedge, returns read words after posedge
  initial begin
    logic [24:0] a, ra;
    int          idx;
    validout = 1'b0; dout = '0; raddr = '0;
    wr_beat = 0; rd_beat = 0; ret_idx = 0;
    forever begin
      @(negedge clk);
      if (reset || (start && !busy)) begin
        wr_beat = 0; rd_beat = 0; ret_idx = 0; rq.delete();
      end else if (notfull && fillcount <= 7'd56) begin
        if (cmd == 3'b010 || cmd == 3'b100) begin
          checkOutput("wr_cmd", 32'(cmd), cfg_mode ? 32'd4 : 32'd2);
          checkOutput("wr_addr", 32'(addr), 32'(exp_wr_addr(wr_beat)));
          checkOutput("wr_din", 32'(din), 32'(exp_wr_din(wr_beat)));
          checkOutput("wr_sz", 32'(sz), cfg_mode ? 32'(cfg_bsz) : 32'd0);
          wr_beat++;
        end else if (cmd == 3'b001 || cmd == 3'b011) begin
          ra = BASE + 25'(rd_beat * words_cur());
          checkOutput("rd_cmd", 32'(cmd), cfg_mode ? 32'd3 : 32'd1);
          checkOutput("rd_addr", 32'(addr), 32'(ra));
          checkOutput("rd_fetching", 32'(fetching), 32'd1);
          for (int k = 0; k < words_cur(); k++) rq.push_back(ra + 25'(k));
          rd_beat++;
        end
      end
      @(posedge clk);
      #1;
      validout = 1'b0;
      if (rq.size() > 0) begin
        a   = rq.pop_front();
        idx = ret_idx;
        ret_idx++;
        if (idx != cfg_drop) begin
          validout = 1'b1;
          raddr    = a;
          dout     = pat(a);
          if (idx < 32 && cfg_mask[idx]) dout[0] = ~dout[0];
          if (idx == cfg_oow) begin
            raddr = BASE + 25'(NX * words_cur());
            dout  = pat(raddr);
          end
        end
      end
    end
  end

  typedef struct {
    logic        mode;
    logic [1:0]  bsz;
    logic [31:0] mask;
    int          drop;
    int          oow;
    int          exp_rd;
    int          exp_err;
    logic        exp_pass;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic startRun(input logic m, input logic [1:0] b);
    @(posedge clk); #2;
    mode = m; blk_sz = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic waitDone(output bit got);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitWrBeats(input int n);
    for (int c = 0; c < 500 && wr_beat < n; c++) @(posedge clk);
    checkOutput("wr_progress", 32'(wr_beat >= n), 32'd1);
  endtask

  task automatic applyStimulus(input vec_t v);
    bit got;
    cfg_mode = v.mode; cfg_bsz = v.bsz; cfg_mask = v.mask;
    cfg_drop = v.drop; cfg_oow = v.oow;
    startRun(v.mode, v.bsz);
    waitDone(got);
    checkOutput("done_seen", 32'(got), 32'd1);
    checkOutput("pass", 32'(pass), 32'(v.exp_pass));
    checkOutput("rd_count", 32'(rd_count), 32'(v.exp_rd));
    checkOutput("err_count", 32'(err_count), 32'(v.exp_err));
    checkOutput("timeout", 32'(timeout), 32'(v.exp_to));
    checkOutput("busy_end", 32'(busy), 32'd0);
    checkOutput("fetching_end", 32'(fetching), 32'd0);
    checkOutput("wr_beats", 32'(wr_beat), 32'(NX * words_cur()));
    checkOutput("rd_beats", 32'(rd_beat), 32'(NX));
  endtask

  initial begin
    bit got;
    reset = 1'b1; start = 1'b0; mode = 1'b0; blk_sz = 2'd0;
    ready = 1'b1; notfull = 1'b1; fillcount = 7'd0;

    vecs[0] = '{1'b0, 2'd0, 32'h0, -1, -1, 4, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 32'h0, -1, -1, 64, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 2'd0, 32'h0, -1, -1, 32, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 32'h6, -1, -1, 4, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 32'h0, -1, 3, 4, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 32'h0, 2, -1, 3, 0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'd3, 32'h8000_0001, -1, -1, 128, 2, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd", 32'(cmd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_fetching", 32'(fetching), 32'd0);
    checkOutput("rst_err", 32'(err_count), 32'd0);
    checkOutput("rst_rd", 32'(rd_count), 32'd0);
    checkOutput("rst_op", 32'(op), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Throttle: freeze mid-WRITE on notfull=0, then on fillcount above the limit
    cfg_mode = 1'b1; cfg_bsz = 2'd0; cfg_mask = '0; cfg_drop = -1; cfg_oow = -1;
    startRun(1'b1, 2'd0);
    waitWrBeats(3);
    #2 notfull = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("hold_nf_cmd", 32'(cmd), 32'd4);
      checkOutput("hold_nf_addr", 32'(addr), 32'(exp_wr_addr(3)));
      checkOutput("hold_nf_din", 32'(din), 32'(exp_wr_din(3)));
    end
    @(posedge clk); #2;
    notfull = 1'b1; fillcount = 7'd57;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("hold_fc_addr", 32'(addr), 32'(exp_wr_addr(3)));
      checkOutput("hold_fc_din", 32'(din), 32'(exp_wr_din(3)));
    end
    checkOutput("hold_beats", 32'(wr_beat), 32'd3);
    @(posedge clk); #2;
    fillcount = 7'd56;
    @(posedge clk); #2;
    checkOutput("resume_beat", 32'(wr_beat), 32'd4);
    fillcount = 7'd0;
    waitDone(got);
    checkOutput("thr_done", 32'(got), 32'd1);
    checkOutput("thr_pass", 32'(pass), 32'd1);
    checkOutput("thr_wr_beats", 32'(wr_beat), 32'd32);
    checkOutput("thr_rd_count", 32'(rd_count), 32'd32);

    // Wait for ready, then reset mid-WRITE
    cfg_mode = 1'b0; cfg_bsz = 2'd0;
    ready = 1'b0;
    startRun(1'b0, 2'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("wait_rdy_busy", 32'(busy), 32'd1);
      checkOutput("wait_rdy_cmd", 32'(cmd), 32'd0);
    end
    ready = 1'b1;
    waitWrBeats(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_cmd", 32'(cmd), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_addr", 32'(addr), 32'd0);
    checkOutput("midrst_din", 32'(din), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Clean restart with a start pulse while busy that must be ignored
    startRun(1'b0, 2'd0);
    waitWrBeats(2);
    #2 start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    checkOutput("busy_start_busy", 32'(busy), 32'd1);
    waitDone(got);
    checkOutput("restart_done", 32'(got), 32'd1);
    checkOutput("restart_pass", 32'(pass), 32'd1);
    checkOutput("restart_wr_beats", 32'(wr_beat), 32'd4);
    checkOutput("restart_rd_beats", 32'(rd_beat), 32'd4);
    checkOutput("restart_rd_count", 32'(rd_count), 32'd4);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
